// File: rtl/step_button_conditioner.sv
// Push-button front end: 2-FF synchroniser, tick-based debouncer, edge detect and a
// press / auto-repeat pulse generator with a running pulse counter, all in the clk domain.
module step_button_conditioner #(
  parameter int unsigned TICK_DIV       = 200000,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY   = 250,
  parameter int unsigned REPEAT_PERIOD  = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       repeat_en,
  output logic       level_out,
  output logic       pulse_out,
  output logic [7:0] pulse_count
);

  localparam int unsigned TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DcntW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned RcntMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RcntW   = (RcntMax > 1) ? $clog2(RcntMax) : 1;

  localparam logic [TickW-1:0] TickLast   = TickW'(TICK_DIV - 1);
  localparam logic [DcntW-1:0] DcntTarget = DcntW'(DEBOUNCE_TICKS);
  localparam logic [RcntW-1:0] DelayLast  = RcntW'(REPEAT_DELAY - 1);
  localparam logic [RcntW-1:0] PeriodLast = RcntW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StHold} state_e;

  logic [1:0]       sync_q, sync_d;
  logic [TickW-1:0] tcnt_q, tcnt_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  state_e           state_q, state_d;
  logic [RcntW-1:0] rcnt_q, rcnt_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       count_q, count_d;

  logic btn_s;
  logic tick;
  logic rise;
  logic fall;
  logic release_now;
  logic released;

  assign btn_s = sync_q[1];
  assign tick  = (tcnt_q == TickLast);

  // Synchroniser, tick divider and debouncer
  always_comb begin
    sync_d      = {sync_q[0], btn_in};
    tcnt_d      = tick ? '0 : tcnt_q + TickW'(1);
    dcnt_d      = dcnt_q;
    level_d     = level_q;
    level_dly_d = level_q;
    if (tick) begin
      if (btn_s != level_q) begin
        if (dcnt_q + DcntW'(1) == DcntTarget) begin
          level_d = ~level_q;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DcntW'(1);
        end
      end else begin
        dcnt_d = '0;
      end
    end
  end

  assign rise = level_q & ~level_dly_q;
  assign fall = ~level_q & level_dly_q;
  // The debounced level only drops on a tick, which is also when repeat pulses fall due.
  // Catching the drop in the same clk lets release win over a coincident repeat pulse.
  assign release_now = level_q & ~level_d;
  assign released    = release_now | fall;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    pulse_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (rise) begin
          pulse_d = 1'b1;
          rcnt_d  = '0;
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (released) begin
          rcnt_d  = '0;
          state_d = StIdle;
        end else if (tick) begin
          if (rcnt_q == DelayLast) begin
            rcnt_d = '0;
            if (repeat_en) begin
              pulse_d = 1'b1;
              state_d = StRepeat;
            end else begin
              state_d = StHold;
            end
          end else begin
            rcnt_d = rcnt_q + RcntW'(1);
          end
        end
      end
      StRepeat: begin
        if (released) begin
          rcnt_d  = '0;
          state_d = StIdle;
        end else if (!repeat_en) begin
          rcnt_d  = '0;
          state_d = StHold;
        end else if (tick) begin
          if (rcnt_q == PeriodLast) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RcntW'(1);
          end
        end
      end
      StHold: begin
        if (released) begin
          rcnt_d  = '0;
          state_d = StIdle;
        end
      end
      default: begin
        rcnt_d  = '0;
        state_d = StIdle;
      end
    endcase
    count_d = count_q + 8'(pulse_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      tcnt_q      <= '0;
      dcnt_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      state_q     <= StIdle;
      rcnt_q      <= '0;
      pulse_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      sync_q      <= sync_d;
      tcnt_q      <= tcnt_d;
      dcnt_q      <= dcnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      pulse_q     <= pulse_d;
      count_q     <= count_d;
    end
  end

  assign level_out   = level_q;
  assign pulse_out   = pulse_q;
  assign pulse_count = count_q;

endmodule

// File: tb/tb_step_button_conditioner.sv
// Bench for step_button_conditioner: expected pulses (count value plus timing window or
// gap from the previous pulse) are queued at stimulus time and matched by a pulse monitor.
module tb_step_button_conditioner;

  localparam int unsigned TickDiv  = 4;
  localparam int unsigned DebTicks = 3;
  localparam int unsigned RepDelay = 5;
  localparam int unsigned RepPer   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       repeat_en;
  logic       level_out;
  logic       pulse_out;
  logic [7:0] pulse_count;

  step_button_conditioner #(
    .TICK_DIV      (TickDiv),
    .DEBOUNCE_TICKS(DebTicks),
    .REPEAT_DELAY  (RepDelay),
    .REPEAT_PERIOD (RepPer)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .level_out  (level_out),
    .pulse_out  (pulse_out),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int lo;
    int hi;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  int   last_pulse = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pulse monitor: every observed pulse must match the oldest queued expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (pulse_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: pulse_out=1 at cycle %0d (count %0d), required no pulse",
                 cyc, pulse_count);
      end else begin
        e = exp_q.pop_front();
        if (pulse_count !== 8'(e.cnt)) begin
          errors++;
          $display("FAIL pulse_count_at_pulse: got %0d, required %0d", pulse_count, e.cnt);
        end
        checks++;
        if (e.gap > 0) begin
          if (cyc != last_pulse + e.gap) begin
            errors++;
            $display("FAIL pulse_gap: got %0d clk, required %0d clk", cyc - last_pulse, e.gap);
          end
        end else if (cyc < e.lo || cyc > e.hi) begin
          errors++;
          $display("FAIL pulse_time: pulse at cycle %0d, required %0d..%0d", cyc, e.lo, e.hi);
        end
      end
      last_pulse = cyc;
    end
  end

  task automatic push_window(input int lo, input int hi);
    exp_t e;
    model_cnt = (model_cnt + 1) % 256;
    e.cnt = model_cnt;
    e.lo  = lo;
    e.hi  = hi;
    e.gap = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_gap(input int gap);
    exp_t e;
    model_cnt = (model_cnt + 1) % 256;
    e.cnt = model_cnt;
    e.lo  = 0;
    e.hi  = 0;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic settle_and_check(input string name);
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses: %0d pulses still expected, required 0", name, exp_q.size());
    end
    checks++;
    if (pulse_count !== 8'(model_cnt)) begin
      errors++;
      $display("FAIL %s_pulse_count: got %0d, required %0d", name, pulse_count, model_cnt);
    end
  endtask

  task automatic test_reset;
    btn_in    = 1'b0;
    repeat_en = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    #2;
    checks++;
    if ({level_out, pulse_out, pulse_count} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: level=%b pulse=%b count=%0d, required all 0",
               level_out, pulse_out, pulse_count);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_cnt = 0;
    exp_q.delete();
  endtask

  task automatic test_clean_press;
    int c0, c1, seen_cyc;
    @(negedge clk);
    c0 = cyc;
    btn_in = 1'b1;
    push_window(c0 + 12, c0 + 15);
    seen_cyc = -1;
    for (int i = 0; i < 30 && seen_cyc < 0; i++) begin
      @(negedge clk);
      if (level_out === 1'b1) seen_cyc = cyc;
    end
    checks++;
    if (seen_cyc < c0 + 11 || seen_cyc > c0 + 14) begin
      errors++;
      $display("FAIL level_rise_time: rose at cycle %0d, required %0d..%0d",
               seen_cyc, c0 + 11, c0 + 14);
    end
    wait_until(c0 + 40);
    btn_in = 1'b0;
    c1 = cyc;
    seen_cyc = -1;
    for (int i = 0; i < 30 && seen_cyc < 0; i++) begin
      @(negedge clk);
      if (level_out === 1'b0) seen_cyc = cyc;
    end
    checks++;
    if (seen_cyc < c1 + 11 || seen_cyc > c1 + 14) begin
      errors++;
      $display("FAIL level_fall_time: fell at cycle %0d, required %0d..%0d",
               seen_cyc, c1 + 11, c1 + 14);
    end
    settle_and_check("clean_press");
  endtask

  task automatic test_bounce;
    int cs;
    int bad;
    bad = 0;
    for (int seg = 0; seg < 10; seg++) begin
      btn_in = (seg % 2 == 0);
      repeat (3) begin
        @(negedge clk);
        if (level_out !== 1'b0) bad++;
      end
    end
    btn_in = 1'b1;
    cs = cyc;
    push_window(cs + 3, cs + 15);
    repeat (2) begin
      @(negedge clk);
      if (level_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bounce_level: level_out high on %0d sampled clks, required 0", bad);
    end
    wait_until(cs + 40);
    btn_in = 1'b0;
    settle_and_check("bounce");
  endtask

  task automatic test_auto_repeat;
    int c0;
    repeat_en = 1'b1;
    @(negedge clk);
    c0 = cyc;
    btn_in = 1'b1;
    // First repeat comes 5 ticks after DELAY is entered, which is 1 clk after a tick.
    push_window(c0 + 12, c0 + 15);
    push_gap(19);
    for (int i = 0; i < 9; i++) push_gap(8);
    wait_until(c0 + 96);
    btn_in = 1'b0;
    settle_and_check("auto_repeat");
    repeat_en = 1'b0;
  endtask

  task automatic test_repeat_disable;
    int c0;
    repeat_en = 1'b1;
    @(negedge clk);
    c0 = cyc;
    btn_in = 1'b1;
    push_window(c0 + 12, c0 + 15);
    push_gap(19);
    wait_until(c0 + 38);
    repeat_en = 1'b0;
    wait_until(c0 + 80);
    btn_in = 1'b0;
    settle_and_check("repeat_disable");
  endtask

  task automatic test_release_race;
    int c0;
    repeat_en = 1'b1;
    @(negedge clk);
    c0 = cyc;
    btn_in = 1'b1;
    push_window(c0 + 12, c0 + 15);
    push_gap(19);
    push_gap(8);
    // Level drops on the very tick the next repeat pulse is due.
    wait_until(c0 + 36);
    btn_in = 1'b0;
    settle_and_check("release_race");
    repeat_en = 1'b0;
    @(negedge clk);
    c0 = cyc;
    btn_in = 1'b1;
    push_window(c0 + 12, c0 + 15);
    wait_until(c0 + 30);
    btn_in = 1'b0;
    settle_and_check("after_race");
  endtask

  task automatic test_wrap;
    int c0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_cnt = 0;
    exp_q.delete();
    repeat_en = 1'b0;
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      c0 = cyc;
      btn_in = 1'b1;
      push_window(c0 + 12, c0 + 15);
      wait_until(c0 + 20);
      btn_in = 1'b0;
      wait_until(c0 + 40);
    end
    settle_and_check("wrap");
    checks++;
    if (pulse_count !== 8'h00) begin
      errors++;
      $display("FAIL wrap_to_zero: got %0d, required 0", pulse_count);
    end
  endtask

  task automatic test_async_reset;
    int c0, c1;
    repeat_en = 1'b1;
    @(negedge clk);
    c0 = cyc;
    btn_in = 1'b1;
    push_window(c0 + 12, c0 + 15);
    push_gap(19);
    wait_until(c0 + 36);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({level_out, pulse_out, pulse_count} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: level=%b pulse=%b count=%0d, required all 0",
               level_out, pulse_out, pulse_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_pulses: %0d pulses still expected, required 0", exp_q.size());
    end
    exp_q.delete();
    model_cnt = 0;
    repeat_en = 1'b0;
    repeat (3) @(negedge clk);
    c1 = cyc;
    reset = 1'b1;
    push_window(c1 + 13, c1 + 13);
    repeat (30) @(negedge clk);
    checks++;
    if (level_out !== 1'b1) begin
      errors++;
      $display("FAIL held_through_reset_level: got %b, required 1", level_out);
    end
    btn_in = 1'b0;
    settle_and_check("async_reset");
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_auto_repeat;
    test_repeat_disable;
    test_release_race;
    test_wrap;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
